// File: rtl/hdmi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_pkg : TMDS control tokens, lane indices, deskew FSM state encoding  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hdmi_pkg;

   localparam logic [9:0] c_ctl_tok0 = 10'h354;
   localparam logic [9:0] c_ctl_tok1 = 10'h0ab;
   localparam logic [9:0] c_ctl_tok2 = 10'h154;
   localparam logic [9:0] c_ctl_tok3 = 10'h2ab;

   localparam int c_ch_b = 0;
   localparam int c_ch_g = 1;
   localparam int c_ch_r = 2;
   localparam int c_nch  = 3;

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } sync_state_e;

   function automatic logic is_ctrl(input logic [9:0] sym);
      return (sym == c_ctl_tok0) || (sym == c_ctl_tok1) ||
             (sym == c_ctl_tok2) || (sym == c_ctl_tok3);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_ctlend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tmds_ctlend : flags the first non-control symbol after >= NCTRL tokens   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tmds_ctlend
   import hdmi_pkg::*;
#(
   parameter int NCTRL = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [9:0] i_sym,
   output logic       o_eoc
);

   localparam int RW = $clog2(NCTRL + 1);
   localparam logic [RW-1:0] c_run_max = RW'(NCTRL);

   logic [RW-1:0] run_q, run_d;
   logic          w_is_ctrl;

   always_comb begin
      w_is_ctrl = is_ctrl(i_sym);
      run_d     = '0;
      if (w_is_ctrl) begin
         run_d = (run_q == c_run_max) ? run_q : run_q + 1'b1;
      end
      o_eoc = !w_is_ctrl && (run_q == c_run_max);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         run_q <= '0;
      end else begin
         run_q <= run_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hdmi_chsync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hdmi_chsync : three-lane TMDS deskew via end-of-control-period alignment |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hdmi_chsync
   import hdmi_pkg::*;
#(
   parameter int LGSKEW  = 3,
   parameter int NCTRL   = 8,
   parameter int MAXMISS = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [9:0]            i_hdmi_r,
   input  logic [9:0]            i_hdmi_g,
   input  logic [9:0]            i_hdmi_b,
   output logic [9:0]            o_hdmi_r,
   output logic [9:0]            o_hdmi_g,
   output logic [9:0]            o_hdmi_b,
   output logic                  o_locked,
   output logic [3*LGSKEW-1:0]   o_skew,
   output logic [15:0]           o_relocks
);

   localparam int MAXSKEW = 1 << LGSKEW;
   localparam int MW      = $clog2(MAXMISS + 1);
   localparam logic [LGSKEW-1:0] c_win_last  = {LGSKEW{1'b1}};
   localparam logic [MW-1:0]     c_miss_last = MW'(MAXMISS - 1);

   logic [9:0]        w_in  [c_nch];
   logic [9:0]        tap_q [c_nch][MAXSKEW];
   logic [9:0]        tap_d [c_nch][MAXSKEW];
   logic [9:0]        out_q [c_nch];
   logic [9:0]        out_d [c_nch];
   logic [LGSKEW-1:0] dly_q [c_nch];
   logic [LGSKEW-1:0] dly_d [c_nch];
   logic [LGSKEW-1:0] arr_q [c_nch];
   logic [LGSKEW-1:0] arr_d [c_nch];
   logic [c_nch-1:0]  w_eoc, w_deoc;

   sync_state_e       state_q, state_d;
   logic              active_q, active_d;
   logic [LGSKEW-1:0] win_q, win_d;
   logic [c_nch-1:0]  rec_q, rec_d;
   logic [MW-1:0]     miss_q, miss_d;
   logic [15:0]       relocks_q, relocks_d;

   logic [LGSKEW-1:0] w_off, w_max;
   logic [c_nch-1:0]  w_rec;
   logic [LGSKEW-1:0] w_arr [c_nch];

   always_comb begin
      w_in[c_ch_b] = i_hdmi_b;
      w_in[c_ch_g] = i_hdmi_g;
      w_in[c_ch_r] = i_hdmi_r;
      for (int c = 0; c < c_nch; c++) begin
         tap_d[c][0] = w_in[c];
         for (int k = 1; k < MAXSKEW; k++) begin
            tap_d[c][k] = tap_q[c][k-1];
         end
         out_d[c] = tap_q[c][dly_q[c]];
      end
   end

   generate
      for (genvar c = 0; c < c_nch; c++) begin : g_det
         tmds_ctlend #(.NCTRL(NCTRL)) u_eoc (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_sym   (tap_q[c][0]),
            .o_eoc   (w_eoc[c])
         );
         tmds_ctlend #(.NCTRL(NCTRL)) u_deoc (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_sym   (tap_q[c][dly_q[c]]),
            .o_eoc   (w_deoc[c])
         );
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      win_d     = win_q;
      rec_d     = rec_q;
      miss_d    = miss_q;
      relocks_d = relocks_q;
      arr_d     = arr_q;
      dly_d     = dly_q;
      w_off     = active_q ? win_q : '0;
      w_rec     = rec_q | w_eoc;
      w_max     = '0;
      for (int c = 0; c < c_nch; c++) begin
         w_arr[c] = (w_eoc[c] && !rec_q[c]) ? w_off : arr_q[c];
         if (w_arr[c] > w_max) begin
            w_max = w_arr[c];
         end
      end

      case (state_q)
         ST_SEARCH: begin
            if (active_q || (|w_eoc)) begin
               if (&w_rec) begin
                  for (int c = 0; c < c_nch; c++) begin
                     dly_d[c] = w_max - w_arr[c];
                  end
                  state_d  = ST_LOCKED;
                  active_d = 1'b0;
                  rec_d    = '0;
                  miss_d   = '0;
                  if (relocks_q != 16'hffff) begin
                     relocks_d = relocks_q + 16'd1;
                  end
               end else if (active_q && (win_q == c_win_last)) begin
                  // Expired window: a late arrival here must not seed a new one
                  active_d = 1'b0;
                  rec_d    = '0;
               end else begin
                  active_d = 1'b1;
                  rec_d    = w_rec;
                  arr_d    = w_arr;
                  win_d    = w_off + 1'b1;
               end
            end
         end
         ST_LOCKED: begin
            if (|w_deoc) begin
               if (&w_deoc) begin
                  miss_d = '0;
               end else if (miss_q == c_miss_last) begin
                  miss_d  = '0;
                  state_d = ST_SEARCH;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_SEARCH;
         active_q  <= 1'b0;
         win_q     <= '0;
         rec_q     <= '0;
         miss_q    <= '0;
         relocks_q <= '0;
         for (int c = 0; c < c_nch; c++) begin
            arr_q[c] <= '0;
            dly_q[c] <= '0;
            out_q[c] <= '0;
            for (int k = 0; k < MAXSKEW; k++) begin
               tap_q[c][k] <= '0;
            end
         end
      end else begin
         state_q   <= state_d;
         active_q  <= active_d;
         win_q     <= win_d;
         rec_q     <= rec_d;
         miss_q    <= miss_d;
         relocks_q <= relocks_d;
         for (int c = 0; c < c_nch; c++) begin
            arr_q[c] <= arr_d[c];
            dly_q[c] <= dly_d[c];
            out_q[c] <= out_d[c];
            for (int k = 0; k < MAXSKEW; k++) begin
               tap_q[c][k] <= tap_d[c][k];
            end
         end
      end
   end

   assign o_hdmi_b  = out_q[c_ch_b];
   assign o_hdmi_g  = out_q[c_ch_g];
   assign o_hdmi_r  = out_q[c_ch_r];
   assign o_locked  = (state_q == ST_LOCKED);
   assign o_skew    = {dly_q[c_ch_r], dly_q[c_ch_g], dly_q[c_ch_b]};
   assign o_relocks = relocks_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_chsync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hdmi_chsync : directed deskew scenarios with hand-computed results    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hdmi_chsync;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] i_r = '0, i_g = '0, i_b = '0;
   logic [9:0] o_r, o_g, o_b;
   logic       o_locked;
   logic [8:0] o_skew;
   logic [15:0] o_relocks;

   int n_cmp = 0;
   int n_err = 0;
   int fo [3];

   hdmi_chsync dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_hdmi_r  (i_r),
      .i_hdmi_g  (i_g),
      .i_hdmi_b  (i_b),
      .o_hdmi_r  (o_r),
      .o_hdmi_g  (o_g),
      .o_hdmi_b  (o_b),
      .o_locked  (o_locked),
      .o_skew    (o_skew),
      .o_relocks (o_relocks)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Lane symbol i: lead data, nc control tokens, then data numbered from 0 after the end
   function automatic logic [9:0] sym(input int i, input int lead, input int nc);
      if (i < lead) return 10'h3e0 | 10'(i & 31);
      if (i < lead + nc) begin
         case (i % 4)
            0:       return 10'h354;
            1:       return 10'h0ab;
            2:       return 10'h154;
            default: return 10'h2ab;
         endcase
      end
      return 10'h3c0 | 10'((i - lead - nc) & 31);
   endfunction

   task automatic run(input int lb, input int lg, input int lr,
                      input int nb, input int ng, input int nr, input int len);
      fo[0] = -1; fo[1] = -1; fo[2] = -1;
      for (int i = 0; i < len; i++) begin
         i_b = sym(i, lb, nb);
         i_g = sym(i, lg, ng);
         i_r = sym(i, lr, nr);
         tick();
         if (fo[0] < 0 && o_b == 10'h3c0) fo[0] = i;
         if (fo[1] < 0 && o_g == 10'h3c0) fo[1] = i;
         if (fo[2] < 0 && o_r == 10'h3c0) fo[2] = i;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_r = '0; i_g = '0; i_b = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_o_b", o_b, 0);
      chk("rst_o_g", o_g, 0);
      chk("rst_o_r", o_r, 0);
      chk("rst_locked", o_locked, 0);
      chk("rst_skew", o_skew, 0);
      chk("rst_relocks", o_relocks, 0);

      // Zero skew
      run(0, 0, 0, 12, 12, 12, 20);
      chk("t1_locked", o_locked, 1);
      chk("t1_skew", o_skew, 0);
      chk("t1_relocks", o_relocks, 1);

      // Blue end at t, red t+1, green t+3 -> {d_r,d_g,d_b} = {2,0,3}
      do_reset();
      run(0, 3, 1, 12, 12, 12, 23);
      chk("t2_locked", o_locked, 1);
      chk("t2_skew", o_skew, 9'h083);
      chk("t2_relocks", o_relocks, 1);
      run(0, 3, 1, 12, 12, 12, 23);
      chk("t2_latency_b", fo[0], 16);
      chk("t2_align_gb", fo[1], fo[0]);
      chk("t2_align_rb", fo[2], fo[0]);
      chk("t2_still_locked", o_locked, 1);

      // Red 8 behind blue/green: out of range
      do_reset();
      run(0, 0, 8, 12, 12, 12, 40);
      chk("t3_locked", o_locked, 0);
      chk("t3_relocks", o_relocks, 0);
      // Red 7 behind: largest correctable skew
      do_reset();
      run(0, 0, 7, 12, 12, 12, 40);
      chk("t3b_locked", o_locked, 1);
      chk("t3b_skew", o_skew, 9'h03f);

      // Control period one token short, then exactly NCTRL
      do_reset();
      run(0, 0, 0, 7, 7, 7, 16);
      chk("t4_short_locked", o_locked, 0);
      chk("t4_short_relocks", o_relocks, 0);
      run(0, 0, 0, 8, 8, 8, 16);
      chk("t4_exact_locked", o_locked, 1);
      chk("t4_exact_relocks", o_relocks, 1);

      // Lock loss: green loses its control-period end (one miss per period)
      do_reset();
      run(0, 0, 0, 12, 12, 12, 20);
      chk("t5_lock", o_locked, 1);
      run(0, 8, 0, 12, 4, 12, 20);
      run(0, 8, 0, 12, 4, 12, 20);
      chk("t5_two_bad", o_locked, 1);
      run(0, 0, 0, 12, 12, 12, 20);
      run(0, 8, 0, 12, 4, 12, 20);
      run(0, 8, 0, 12, 4, 12, 20);
      chk("t5_cleared", o_locked, 1);
      run(0, 8, 0, 12, 4, 12, 20);
      chk("t5_third_bad", o_locked, 0);
      chk("t5_relocks", o_relocks, 1);
      run(0, 0, 0, 12, 12, 12, 20);
      chk("t5_relock", o_locked, 1);
      chk("t5_relocks2", o_relocks, 2);

      // Reset in the middle of a search window
      do_reset();
      run(0, 0, 0, 12, 0, 0, 14);
      chk("t6_pre_locked", o_locked, 0);
      chk("t6_pre_o_b_nonzero", (o_b != 0), 1);
      rst = 1'b1;
      tick();
      chk("t6_o_b", o_b, 0);
      chk("t6_o_g", o_g, 0);
      chk("t6_o_r", o_r, 0);
      chk("t6_locked", o_locked, 0);
      chk("t6_relocks", o_relocks, 0);
      rst = 1'b0;
      run(0, 0, 0, 12, 12, 12, 20);
      chk("t6_post_locked", o_locked, 1);
      chk("t6_post_skew", o_skew, 0);
      chk("t6_post_relocks", o_relocks, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
